reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp_pkg.sv | 31 +++
 rtl/reg_file_clr_seq.sv | 65 ++++++
 rtl/reg_file_mp.sv | 86 ++++++++
 tb/tb_reg_file_mp.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the clear-sequencer state encoding and the byte-lane merge used
// both for the array write path and for the optional read bypass.
package reg_file_mp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Widest word the merge helper handles; callers cast down to their width.
  localparam int unsigned MAX_DATA_WIDTH = 256;
  localparam int unsigned MAX_LANES      = MAX_DATA_WIDTH / 8;

  // Replace each byte lane of old_data with new_data wherever be is set.
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_data,
    input logic [MAX_DATA_WIDTH-1:0] new_data,
    input logic [MAX_LANES-1:0]      be
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_data;
    for (int i = 0; i < int'(MAX_LANES); i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_data[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer: walks every address once, one word per cycle, and
// signals completion with a single-cycle clr_done pulse. The counter
// carries one extra bit so the last address is recognised by the carry
// out rather than by a wrapped compare.
module reg_file_clr_seq
  import reg_file_mp_pkg::*;
#(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  clr_done,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  clr_state_t          state;
  logic [ADDR_WIDTH:0] count;
  logic [ADDR_WIDTH:0] count_next;

  assign count_next = count + (ADDR_WIDTH+1)'(1);
  assign clr_addr   = count[ADDR_WIDTH-1:0];

  // Sweep FSM with registered busy/clr_we/clr_done; clr_req is ignored mid-sweep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      busy     <= 1'b0;
      clr_we   <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state  <= CLEAR;
            count  <= '0;
            busy   <= 1'b1;
            clr_we <= 1'b1;
          end
        end
        CLEAR: begin
          if (count_next[ADDR_WIDTH]) begin
            state    <= IDLE;
            count    <= '0;
            busy     <= 1'b0;
            clr_we   <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            count <= count_next;
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          clr_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Register file with one byte-enabled write port, two registered read
// ports and a background clear sweep. Writes arriving during a sweep are
// dropped and flagged on wr_drop.
// Optional feature: define REG_FILE_BYPASS_EN to forward an accepted
// write to a same-cycle read of the same address (byte-merged per wr_be).
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_a,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_b,
  output logic [DATA_WIDTH-1:0]   rd_data_a,
  output logic [DATA_WIDTH-1:0]   rd_data_b,
  input  logic                    clr_req,
  output logic                    busy,
  output logic                    clr_done,
  output logic                    wr_drop
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic                             clr_we;
  logic [ADDR_WIDTH-1:0]            clr_addr;
  logic                             wr_accept;
  logic [DATA_WIDTH-1:0]            wr_merged;
  logic [DATA_WIDTH-1:0]            next_a;
  logic [DATA_WIDTH-1:0]            next_b;

  reg_file_clr_seq #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clr_seq (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_accept = wr_en && !busy;
  assign wr_drop   = wr_en && busy;
  assign wr_merged = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(mem[wr_addr]),
                                            MAX_DATA_WIDTH'(wr_data),
                                            MAX_LANES'(wr_be)));

`ifdef REG_FILE_BYPASS_EN
  assign next_a = (wr_accept && (wr_addr == rd_addr_a)) ? wr_merged : mem[rd_addr_a];
  assign next_b = (wr_accept && (wr_addr == rd_addr_b)) ? wr_merged : mem[rd_addr_b];
`else
  assign next_a = mem[rd_addr_a];
  assign next_b = mem[rd_addr_b];
`endif

  // Array update: the sweep owns the array while busy, otherwise accepted writes land.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem <= '0;
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_accept) begin
      mem[wr_addr] <= wr_merged;
    end
  end

  // Both read ports register their word every cycle, independently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_data_a <= next_a;
      rd_data_b <= next_b;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp (DATA_WIDTH=16, ADDR_WIDTH=3): a vector
// table for plain writes/reads and byte lanes, then hand sequences for the
// clear sweep, same-cycle read/write and reset during a sweep.
module tb_reg_file_mp;

  localparam int DW = 16;
  localparam int AW = 3;

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [1:0]    wr_be;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          chk;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [1:0]    wr_be = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] rd_addr_a = '0;
  logic [AW-1:0] rd_addr_b = '0;
  logic          clr_req = 1'b0;
  logic [DW-1:0] rd_data_a;
  logic [DW-1:0] rd_data_b;
  logic          busy;
  logic          clr_done;
  logic          wr_drop;

  int tests_run = 0;
  int tests_failed = 0;

  reg_file_mp #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_be     (wr_be),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .clr_req   (clr_req),
    .busy      (busy),
    .clr_done  (clr_done),
    .wr_drop   (wr_drop)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkv(logic we, logic [AW-1:0] wa, logic [1:0] be,
                               logic [DW-1:0] wd, logic [AW-1:0] ra,
                               logic [AW-1:0] rb, logic chk,
                               logic [DW-1:0] ea, logic [DW-1:0] eb);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_be = be; v.wr_data = wd;
    v.rd_addr_a = ra; v.rd_addr_b = rb; v.chk = chk; v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  task automatic driveInputs(input vec_t v);
    wr_en = v.wr_en; wr_addr = v.wr_addr; wr_be = v.wr_be; wr_data = v.wr_data;
    rd_addr_a = v.rd_addr_a; rd_addr_b = v.rd_addr_b;
  endtask

  task automatic applyStimulus(input vec_t v);
    driveInputs(v);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  vec_t tbl [22];
  vec_t idle_v;

  initial begin
    int busy_cycles;
    int done_pulses;
    int j;

    // Table: reset-state read, full write pass, crossed reads, byte lanes.
    tbl[0]  = mkv(1'b0, 3'd0, 2'b00, 16'h0000, 3'd0, 3'd7, 1'b1, 16'h0000, 16'h0000);
    tbl[1]  = mkv(1'b1, 3'd0, 2'b11, 16'hFF00, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000);
    tbl[2]  = mkv(1'b1, 3'd1, 2'b11, 16'hFEFF, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000);
    tbl[3]  = mkv(1'b1, 3'd2, 2'b11, 16'hFEFE, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000);
    tbl[4]  = mkv(1'b1, 3'd3, 2'b11, 16'hFEFD, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000);
    tbl[5]  = mkv(1'b1, 3'd4, 2'b11, 16'hFEFC, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000);
    tbl[6]  = mkv(1'b1, 3'd5, 2'b11, 16'hFEFB, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000);
    tbl[7]  = mkv(1'b1, 3'd6, 2'b11, 16'hFEFA, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000);
    tbl[8]  = mkv(1'b1, 3'd7, 2'b11, 16'hFEF9, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000);
    tbl[9]  = mkv(1'b0, 3'd0, 2'b00, 16'h0000, 3'd0, 3'd7, 1'b1, 16'hFF00, 16'hFEF9);
    tbl[10] = mkv(1'b0, 3'd0, 2'b00, 16'h0000, 3'd1, 3'd6, 1'b1, 16'hFEFF, 16'hFEFA);
    tbl[11] = mkv(1'b0, 3'd0, 2'b00, 16'h0000, 3'd2, 3'd5, 1'b1, 16'hFEFE, 16'hFEFB);
    tbl[12] = mkv(1'b0, 3'd0, 2'b00, 16'h0000, 3'd3, 3'd4, 1'b1, 16'hFEFD, 16'hFEFC);
    tbl[13] = mkv(1'b0, 3'd0, 2'b00, 16'h0000, 3'd4, 3'd3, 1'b1, 16'hFEFC, 16'hFEFD);
    tbl[14] = mkv(1'b0, 3'd0, 2'b00, 16'h0000, 3'd5, 3'd2, 1'b1, 16'hFEFB, 16'hFEFE);
    tbl[15] = mkv(1'b0, 3'd0, 2'b00, 16'h0000, 3'd6, 3'd1, 1'b1, 16'hFEFA, 16'hFEFF);
    tbl[16] = mkv(1'b0, 3'd0, 2'b00, 16'h0000, 3'd7, 3'd0, 1'b1, 16'hFEF9, 16'hFF00);
    tbl[17] = mkv(1'b1, 3'd2, 2'b11, 16'hFFFD, 3'd0, 3'd7, 1'b1, 16'hFF00, 16'hFEF9);
    tbl[18] = mkv(1'b1, 3'd2, 2'b01, 16'h1234, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000);
    tbl[19] = mkv(1'b1, 3'd3, 2'b10, 16'h5678, 3'd2, 3'd2, 1'b1, 16'hFF34, 16'hFF34);
    tbl[20] = mkv(1'b1, 3'd4, 2'b00, 16'h0000, 3'd3, 3'd3, 1'b1, 16'h56FD, 16'h56FD);
    tbl[21] = mkv(1'b0, 3'd0, 2'b00, 16'h0000, 3'd4, 3'd1, 1'b1, 16'hFEFC, 16'hFEFF);
    idle_v  = mkv(1'b0, 3'd0, 2'b00, 16'h0000, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000);

    // Asynchronous reset: outputs must clear before any clock edge.
    #3 reset_n = 1'b0;
    #1;
    checkBit("reset_busy", busy, 1'b0);
    checkBit("reset_clr_done", clr_done, 1'b0);
    checkBit("reset_wr_drop", wr_drop, 1'b0);
    checkOutput("reset_rd_a", rd_data_a, 16'h0000);
    checkOutput("reset_rd_b", rd_data_b, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 22; k++) begin
      applyStimulus(tbl[k]);
      if (tbl[k].chk) begin
        checkOutput($sformatf("vec%0d_a", k), rd_data_a, tbl[k].exp_a);
        checkOutput($sformatf("vec%0d_b", k), rd_data_b, tbl[k].exp_b);
      end
    end

    // Clear sweep: count busy cycles, re-request mid-sweep, drop a write, read mid-sweep.
    driveInputs(idle_v);
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    busy_cycles = 0;
    done_pulses = 0;
    while (busy && busy_cycles < 20) begin
      vec_t sv;
      j = busy_cycles;
      busy_cycles++;
      sv = idle_v;
      if (j == 3) begin
        sv.rd_addr_a = 3'd1;
        sv.rd_addr_b = 3'd6;
      end
      if (j == 4) begin
        sv.wr_en = 1'b1; sv.wr_addr = 3'd0; sv.wr_be = 2'b11; sv.wr_data = 16'h1111;
      end
      driveInputs(sv);
      clr_req = (j == 2);
      #1;
      if (j == 4) checkBit("sweep_wr_drop", wr_drop, 1'b1);
      @(posedge clk);
      #1;
      clr_req = 1'b0;
      if (clr_done) done_pulses++;
      if (j == 3) begin
        checkOutput("sweep_read_cleared", rd_data_a, 16'h0000);
        checkOutput("sweep_read_old", rd_data_b, 16'hFEFA);
      end
    end
    driveInputs(idle_v);
    checkCount("sweep_busy_cycles", busy_cycles, 8);
    checkBit("sweep_done_pulse", clr_done, 1'b1);
    @(posedge clk);
    #1;
    if (clr_done) done_pulses++;
    checkBit("sweep_done_falls", clr_done, 1'b0);
    checkCount("sweep_done_count", done_pulses, 1);
    checkBit("sweep_busy_idle", busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(mkv(1'b0, 3'd0, 2'b00, 16'h0000, 3'(i), 3'(7 - i), 1'b0, 16'h0000, 16'h0000));
      checkOutput($sformatf("cleared_a%0d", i), rd_data_a, 16'h0000);
      checkOutput($sformatf("cleared_b%0d", 7 - i), rd_data_b, 16'h0000);
    end

    // Same-cycle write and read of one address, full word then low lane only.
    driveInputs(mkv(1'b1, 3'd5, 2'b11, 16'hABCD, 3'd5, 3'd5, 1'b0, 16'h0000, 16'h0000));
    #1;
    checkBit("idle_wr_drop", wr_drop, 1'b0);
    @(posedge clk);
    #1;
`ifdef REG_FILE_BYPASS_EN
    checkOutput("same_cycle_a", rd_data_a, 16'hABCD);
    checkOutput("same_cycle_b", rd_data_b, 16'hABCD);
`else
    checkOutput("same_cycle_a", rd_data_a, 16'h0000);
    checkOutput("same_cycle_b", rd_data_b, 16'h0000);
`endif
    applyStimulus(mkv(1'b1, 3'd5, 2'b01, 16'h7777, 3'd5, 3'd4, 1'b0, 16'h0000, 16'h0000));
`ifdef REG_FILE_BYPASS_EN
    checkOutput("same_cycle_lane_a", rd_data_a, 16'hAB77);
`else
    checkOutput("same_cycle_lane_a", rd_data_a, 16'hABCD);
`endif
    checkOutput("same_cycle_other_b", rd_data_b, 16'h0000);
    applyStimulus(mkv(1'b0, 3'd0, 2'b00, 16'h0000, 3'd5, 3'd5, 1'b0, 16'h0000, 16'h0000));
    checkOutput("after_write_a", rd_data_a, 16'hAB77);

    // clr_req together with a write, then reset at sweep cycle 4.
    driveInputs(mkv(1'b1, 3'd6, 2'b11, 16'h9999, 3'd5, 3'd6, 1'b0, 16'h0000, 16'h0000));
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    driveInputs(mkv(1'b0, 3'd0, 2'b00, 16'h0000, 3'd5, 3'd6, 1'b0, 16'h0000, 16'h0000));
    checkBit("clr_with_write_busy", busy, 1'b1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checkBit("mid_sweep_busy", busy, 1'b1);
    checkOutput("mid_sweep_a", rd_data_a, 16'hAB77);
    checkOutput("clr_with_write_b", rd_data_b, 16'h9999);
    #2 reset_n = 1'b0;
    #1;
    checkBit("abort_busy", busy, 1'b0);
    checkBit("abort_clr_done", clr_done, 1'b0);
    checkBit("abort_wr_drop", wr_drop, 1'b0);
    checkOutput("abort_rd_a", rd_data_a, 16'h0000);
    checkOutput("abort_rd_b", rd_data_b, 16'h0000);
    repeat (2) begin
      @(posedge clk);
      #1;
      checkBit("abort_hold_clr_done", clr_done, 1'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkBit("post_reset_clr_done", clr_done, 1'b0);
    checkBit("post_reset_busy", busy, 1'b0);
    applyStimulus(mkv(1'b1, 3'd1, 2'b11, 16'h0055, 3'd5, 3'd6, 1'b0, 16'h0000, 16'h0000));
    checkOutput("post_reset_mem5", rd_data_a, 16'h0000);
    checkOutput("post_reset_mem6", rd_data_b, 16'h0000);
    applyStimulus(mkv(1'b0, 3'd0, 2'b00, 16'h0000, 3'd1, 3'd1, 1'b0, 16'h0000, 16'h0000));
    checkOutput("post_reset_write_a", rd_data_a, 16'h0055);
    checkOutput("post_reset_write_b", rd_data_b, 16'h0055);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
